// File: rtl/sram_seq_ctrl.sv
// sram_seq_ctrl: one-at-a-time read/write sequencer for an asynchronous 16-bit SRAM.
// Generates setup / strobe / hold / turnaround timing in whole clk cycles.
// Optional feature macro: SRAM_AUTO_DESELECT_EN. When defined, the chip is deselected
// (ce_n=1, ce2=0) in IDLE and in reset. When undefined, the chip stays selected.
// Every output is registered. Each output's next value is decoded from the next state,
// so a registered output always matches the state it belongs to.
module sram_seq_ctrl #(
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WR_CYCLES   = 2,
    parameter int unsigned RD_CYCLES   = 2,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_ce2,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    // Reject out-of-range timing parameters at elaboration.
    if (WR_CYCLES < 1 || WR_CYCLES > 15) begin : g_chk_wr
        $error("sram_seq_ctrl: WR_CYCLES must be in 1..15");
    end
    if (RD_CYCLES < 1 || RD_CYCLES > 15) begin : g_chk_rd
        $error("sram_seq_ctrl: RD_CYCLES must be in 1..15");
    end
    if (TURN_CYCLES > 15) begin : g_chk_turn
        $error("sram_seq_ctrl: TURN_CYCLES must be in 0..15");
    end

    // Counter preload values. The counter counts down to zero, so a phase that lasts N
    // cycles loads N-1.
    localparam logic [3:0] WrLoad   = 4'(WR_CYCLES - 1);
    localparam logic [3:0] RdLoad   = 4'(RD_CYCLES - 1);
    localparam logic [3:0] TurnLoad = 4'(TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StRdPulse,
        StRdTurn
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept;
    logic       capture;
    logic       rsp_valid_d;
    logic       ready_d;
    logic       we_n_d;
    logic       oe_n_d;
    logic       dq_oe_d;

    assign accept = req_valid & req_ready;

    // Next-state, phase counter and read-capture decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_wr) begin
                        state_d = StWrSetup;
                    end else begin
                        state_d = StRdPulse;
                        cnt_d   = RdLoad;
                    end
                end
            end
            StWrSetup: begin
                state_d = StWrPulse;
                cnt_d   = WrLoad;
            end
            StWrPulse: begin
                if (cnt_q == 4'd0) begin
                    state_d     = StWrHold;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrHold: begin
                state_d = StIdle;
            end
            StRdPulse: begin
                if (cnt_q == 4'd0) begin
                    capture     = 1'b1;
                    rsp_valid_d = 1'b1;
                    if (TURN_CYCLES == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StRdTurn;
                        cnt_d   = TurnLoad;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRdTurn: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobe decode from the next state. WE and OE are never active together, and
    // DQ is driven only in write states.
    always_comb begin
        ready_d = (state_d == StIdle);
        we_n_d  = (state_d != StWrPulse);
        oe_n_d  = (state_d != StRdPulse);
        dq_oe_d = (state_d == StWrSetup) || (state_d == StWrPulse) || (state_d == StWrHold);
    end

    // Control state and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_ready  <= ready_d;
            rsp_valid  <= rsp_valid_d;
            sram_we_n  <= we_n_d;
            sram_oe_n  <= oe_n_d;
            sram_dq_oe <= dq_oe_d;
        end
    end

    // Command latch on accept. The read data is captured on the edge that ends the OE pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_addr <= '0;
            sram_dq_o <= '0;
            sram_lb_n <= 1'b1;
            sram_ub_n <= 1'b1;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                sram_addr <= req_addr;
                sram_dq_o <= req_wdata;
                // Reads always fetch both bytes.
                sram_lb_n <= req_wr ? ~req_be[0] : 1'b0;
                sram_ub_n <= req_wr ? ~req_be[1] : 1'b0;
            end
            if (capture) begin
                rsp_rdata <= sram_dq_i;
            end
        end
    end

`ifdef SRAM_AUTO_DESELECT_EN
    // The chip is selected only while a command is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_ce_n <= 1'b1;
            sram_ce2  <= 1'b0;
        end else begin
            sram_ce_n <= (state_d == StIdle);
            sram_ce2  <= (state_d != StIdle);
        end
    end
`else
    // The chip is permanently selected, including during reset.
    always_ff @(posedge clk) begin
        sram_ce_n <= 1'b0;
        sram_ce2  <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sram_seq_ctrl.sv
// Directed bench for sram_seq_ctrl. It uses the default parameters
// (WR_CYCLES=2, RD_CYCLES=2, TURN_CYCLES=1) and a behavioural byte-lane SRAM model.
module tb_sram_seq_ctrl;

`ifdef SRAM_AUTO_DESELECT_EN
    localparam bit AutoDes = 1'b1;
`else
    localparam bit AutoDes = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [21:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [21:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_i;
    logic        sram_ce_n;
    logic        sram_ce2;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_lb_n;
    logic        sram_ub_n;

    int n_pass  = 0;
    int n_total = 0;
    int viol    = 0;

    logic [15:0] mem [logic [21:0]];

    always #5 clk = ~clk;

    sram_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_ce_n  (sram_ce_n),
        .sram_ce2   (sram_ce2),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_lb_n  (sram_lb_n),
        .sram_ub_n  (sram_ub_n)
    );

    // SRAM model: writes byte lanes while WE is low and returns the addressed word while
    // OE is low. It acts mid-cycle, so the data is stable at the next rising edge.
    always @(negedge clk) begin
        logic [15:0] w;
        logic        sel;
        sel = (sram_ce_n === 1'b0) && (sram_ce2 === 1'b1);
        if (sel && sram_we_n === 1'b0) begin
            w = mem.exists(sram_addr) ? mem[sram_addr] : 16'h0000;
            if (!sram_lb_n) w[7:0] = sram_dq_o[7:0];
            if (!sram_ub_n) w[15:8] = sram_dq_o[15:8];
            mem[sram_addr] = w;
        end
        if (sel && sram_oe_n === 1'b0) begin
            sram_dq_i = mem.exists(sram_addr) ? mem[sram_addr] : 16'h0000;
        end else begin
            sram_dq_i = 16'h0000;
        end
    end

    // Protocol monitor: counts cycles where WE and OE are both low, and cycles where
    // DQ is driven while OE is low.
    always @(negedge clk) begin
        if (sram_we_n === 1'b0 && sram_oe_n === 1'b0) viol++;
        if (sram_dq_oe === 1'b1 && sram_oe_n === 1'b0) viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issues one command. It returns the number of cycles from accept to rsp_valid
    // (-1 on timeout), and how many of those cycles had WE low and OE low.
    // It ends on the negedge of the cycle that carries rsp_valid.
    task automatic run_cmd(input logic wr, input logic [21:0] a, input logic [15:0] d,
                           input logic [1:0] be, output int lat, output int we_lo,
                           output int oe_lo);
        lat   = -1;
        we_lo = 0;
        oe_lo = 0;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (!sram_we_n) we_lo++;
            if (!sram_oe_n) oe_lo++;
            if (rsp_valid) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat, we_lo, oe_lo, acc, np, nrsp;
        int pulse_c [3];

        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = 2'b00;
        mem[22'h3FFFFF] = 16'hA5C3;
        mem[22'h000010] = 16'hFFFF;

        // 1: reset values
        repeat (3) @(negedge clk);
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe_n", sram_oe_n, 1);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ready", req_ready, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_lb_ub", {sram_lb_n, sram_ub_n}, 2'b11);
        check("rst_ce_n", sram_ce_n, AutoDes ? 1 : 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);
        check("idle_ce2", sram_ce2, AutoDes ? 0 : 1);

        // 2: full write, traced cycle by cycle
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 22'h000001;
        req_wdata = 16'h0005;
        req_be    = 2'b11;
        @(negedge clk);
        req_valid = 1'b0;
        check("wr_setup_we_n", sram_we_n, 1);
        check("wr_setup_dq_oe", sram_dq_oe, 1);
        check("wr_setup_ready", req_ready, 0);
        check("wr_dq_o", sram_dq_o, 16'h0005);
        check("wr_addr", sram_addr, 22'h000001);
        check("wr_lb_ub", {sram_lb_n, sram_ub_n}, 2'b00);
        check("wr_setup_ce_n", sram_ce_n, 0);
        @(negedge clk);
        check("wr_pulse1_we_n", sram_we_n, 0);
        @(negedge clk);
        check("wr_pulse2_we_n", sram_we_n, 0);
        check("wr_pulse2_rsp", rsp_valid, 0);
        @(negedge clk);
        check("wr_hold_we_n", sram_we_n, 1);
        check("wr_hold_dq_oe", sram_dq_oe, 1);
        check("wr_hold_rsp", rsp_valid, 1);
        @(negedge clk);
        check("wr_done_ready", req_ready, 1);
        check("wr_done_rsp", rsp_valid, 0);
        check("wr_done_dq_oe", sram_dq_oe, 0);

        // 3: read the preloaded top word
        run_cmd(1'b0, 22'h3FFFFF, 16'h0000, 2'b00, lat, we_lo, oe_lo);
        check("rd_latency", lat, 3);
        check("rd_oe_cycles", oe_lo, 2);
        check("rd_rdata", rsp_rdata, 16'hA5C3);
        check("rd_turn_oe_n", sram_oe_n, 1);
        check("rd_turn_ready", req_ready, 0);
        @(negedge clk);
        check("rd_ready_after_turn", req_ready, 1);
        check("rd_rdata_held", rsp_rdata, 16'hA5C3);

        // Read back the word from test 2
        run_cmd(1'b0, 22'h000001, 16'h0000, 2'b00, lat, we_lo, oe_lo);
        check("rd_back_addr1", rsp_rdata, 16'h0005);

        // 4: byte lanes
        run_cmd(1'b1, 22'h000010, 16'h1234, 2'b01, lat, we_lo, oe_lo);
        check("wr_be01_latency", lat, 4);
        check("wr_be01_we_cycles", we_lo, 2);
        run_cmd(1'b0, 22'h000010, 16'h0000, 2'b00, lat, we_lo, oe_lo);
        check("rd_be01", rsp_rdata, 16'hFF34);
        run_cmd(1'b1, 22'h000010, 16'hABCD, 2'b00, lat, we_lo, oe_lo);
        check("wr_be00_rsp", lat, 4);
        run_cmd(1'b0, 22'h000010, 16'h0000, 2'b00, lat, we_lo, oe_lo);
        check("rd_be00_unchanged", rsp_rdata, 16'hFF34);
        @(negedge clk);

        // 5: req_valid held high for three back-to-back writes
        acc = 0;
        np  = 0;
        for (int i = 0; i < 3; i++) pulse_c[i] = -100;
        req_wr    = 1'b1;
        req_addr  = 22'h000020;
        req_wdata = 16'hBEEF;
        req_be    = 2'b11;
        req_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (acc == 3) req_valid = 1'b0;
            if (req_valid && req_ready) acc++;
            if (rsp_valid) begin
                if (np < 3) pulse_c[np] = c;
                np++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_accepts", acc, 3);
        check("b2b_rsp_pulses", np, 3);
        // WR_CYCLES+2 = 4 cycles between pulses, so pulses are 5 cycles apart.
        check("b2b_spacing_1", pulse_c[1] - pulse_c[0], 5);
        check("b2b_spacing_2", pulse_c[2] - pulse_c[1], 5);

        // 6: reset during WR_PULSE aborts the write without a response
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 22'h000030;
        req_wdata = 16'h7777;
        req_be    = 2'b11;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_pulse_we_n", sram_we_n, 0);
        check("abort_in_pulse_ce_n", sram_ce_n, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_we_n", sram_we_n, 1);
        check("abort_dq_oe", sram_dq_oe, 0);
        check("abort_ready", req_ready, 0);
        check("abort_rsp", rsp_valid, 0);
        check("abort_ce_n", sram_ce_n, AutoDes ? 1 : 0);
        rst  = 1'b0;
        nrsp = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        check("abort_no_rsp", nrsp, 0);
        check("abort_ready_again", req_ready, 1);
        check("abort_idle_ce_n", sram_ce_n, AutoDes ? 1 : 0);

        check("strobe_overlap", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
